fifo_wr_framer: RTL and testbench

FIFO_WR_FRAMER -- requirements
Module: fifo_wr_framer

---
 rtl/fifo_wr_framer.sv | 120 ++++++++++++
 tb/tb_fifo_wr_framer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_framer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_framer
//  Purpose  : Frames an upstream payload stream into an async FIFO as
//             SYNC header, payload words, then an XOR checksum word.
//             A single output register decouples the FIFO full flag.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_framer #(
  parameter int unsigned   DW   = 8,
  parameter logic [DW-1:0] SYNC = 8'hA5
) (
  input  logic          clk_wr,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          full,
  output logic          we,
  output logic [DW-1:0] wdata,
  output logic [7:0]    pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic [DW-1:0] csum_q, csum_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          w_slot_free;
  logic          w_load;
  logic [DW-1:0] w_load_word;

  // The output slot can take a new word if empty or draining this cycle.
  assign w_slot_free = ~ov_q | ~full;
  assign we          = ov_q & ~full;
  assign wdata       = od_q;
  assign pkt_cnt     = cnt_q;

  // Framing FSM: decides which word (if any) enters the output slot.
  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    w_load      = 1'b0;
    w_load_word = '0;
    s_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        // Header is emitted only once a packet is actually waiting.
        if (s_valid && w_slot_free) begin
          w_load      = 1'b1;
          w_load_word = SYNC;
          csum_d      = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        s_ready = w_slot_free;
        if (s_valid && w_slot_free) begin
          w_load      = 1'b1;
          w_load_word = s_data;
          csum_d      = csum_q ^ s_data;
          if (s_last) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_word = csum_q;
          cnt_d       = cnt_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output slot next-state: load wins, otherwise a completed write empties it.
  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    if (w_load) begin
      ov_d = 1'b1;
      od_d = w_load_word;
    end else if (we) begin
      ov_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_wr or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      od_q    <= '0;
      csum_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_framer
//  Purpose  : Directed scoreboard bench for fifo_wr_framer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_framer;

  localparam int unsigned   DW   = 8;
  localparam logic [DW-1:0] SYNC = 8'hA5;

  logic          clk_wr = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          full;
  logic          we;
  logic [DW-1:0] wdata;
  logic [7:0]    pkt_cnt;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] sb[$];
  logic [7:0]    exp_cnt;

  fifo_wr_framer #(.DW(DW), .SYNC(SYNC)) dut (
    .clk_wr  (clk_wr),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .full    (full),
    .we      (we),
    .wdata   (wdata),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every FIFO write must match the oldest expected word.
  always @(negedge clk_wr) begin
    if (we === 1'b1) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed %0h expected none", wdata);
      end
      if (sb.size() != 0) begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        n_vec++;
        assert (wdata === e) else begin
          n_err++;
          $error("FAIL wdata: observed %0h expected %0h", wdata, e);
        end
      end
    end
  end

  // Drive one packet; expected header, payload and checksum are queued first.
  task automatic send(input logic [DW-1:0] w[8], input int n, input bit gap, output int cycles);
    logic [DW-1:0] cs;
    bit            acc;
    int            guard;
    cs = '0;
    sb.push_back(SYNC);
    for (int i = 0; i < n; i++) begin
      sb.push_back(w[i]);
      cs = cs ^ w[i];
    end
    sb.push_back(cs);
    exp_cnt = exp_cnt + 8'd1;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        s_valid = 1'b0;
        s_data  = 8'hEE;
        s_last  = 1'b1;
        repeat (2) @(posedge clk_wr);
        #1;
      end
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = (i == n - 1);
      acc     = 1'b0;
      guard   = 0;
      while (!acc && guard < 50) begin
        @(negedge clk_wr);
        acc = s_ready;
        @(posedge clk_wr);
        #1;
        cycles++;
        guard++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk_wr);
      #2;
      guard++;
    end
    chk({tag, "_drain_left"}, sb.size(), 32'd0);
    chk({tag, "_pkt_cnt"}, {24'd0, pkt_cnt}, {24'd0, exp_cnt});
  endtask

  initial begin
    logic [DW-1:0] pk[8];
    int            cyc;

    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; full = 1'b0;
    exp_cnt = 8'd0;
    repeat (2) @(posedge clk_wr);
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wdata", {24'd0, wdata}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
    rst = 1'b1;
    @(posedge clk_wr);
    #1;

    // Three-word packet at full rate.
    pk = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(pk, 3, 1'b0, cyc);
    chk("rate_cycles", cyc, 32'd4);
    drain("pkt3");

    // Single-word packet: checksum equals the word.
    pk = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(pk, 1, 1'b0, cyc);
    drain("single");

    // Backpressure from the FIFO right after the header loads.
    pk = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fork
      send(pk, 3, 1'b0, cyc);
      begin
        @(posedge clk_wr);
        #1;
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_wr);
          chk("stall_we", {31'd0, we}, 32'd0);
          chk("stall_wdata", {24'd0, wdata}, {24'd0, SYNC});
          chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
          @(posedge clk_wr);
        end
        #1;
        full = 1'b0;
      end
    join
    drain("stall");

    // Upstream gaps mid-packet, including a payload word equal to SYNC.
    pk = '{8'hC3, 8'h3C, SYNC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(pk, 3, 1'b1, cyc);
    drain("gap");

    // Back-to-back packets without idle between them.
    pk = '{8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(pk, 2, 1'b0, cyc);
    pk = '{SYNC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(pk, 1, 1'b0, cyc);
    drain("b2b");

    // Reset mid-packet: header and first word reach the FIFO, nothing after.
    sb.push_back(SYNC);
    sb.push_back(8'h10);
    s_valid = 1'b1; s_data = 8'h10; s_last = 1'b0;
    @(posedge clk_wr); #1;
    @(posedge clk_wr); #1;
    s_data = 8'h20;
    @(posedge clk_wr); #1;
    rst = 1'b0;
    #1;
    exp_cnt = 8'd0;
    chk("midrst_we", {31'd0, we}, 32'd0);
    chk("midrst_pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
    chk("midrst_wdata", {24'd0, wdata}, 32'd0);
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk_wr); #1;
    rst = 1'b1;
    chk("midrst_sb_empty", sb.size(), 32'd0);
    repeat (4) @(posedge clk_wr);
    #1;
    pk = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(pk, 1, 1'b0, cyc);
    drain("post_rst");

    // Packet counter wrap across 256 packets from a fresh reset.
    rst = 1'b0;
    #1;
    exp_cnt = 8'd0;
    @(posedge clk_wr); #1;
    rst = 1'b1;
    for (int p = 0; p < 256; p++) begin
      pk = '{8'(p), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send(pk, 1, 1'b0, cyc);
    end
    drain("wrap");
    chk("wrap_zero", {24'd0, pkt_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute runaway guard.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
